// File: rtl/denise_palette_writer.sv
// Streams 24-bit RGB palette entries into the Denise colour table as COLORxx register writes.
// Define DENISE_PALWR_LOCT_EN for AGA two-write (high/low nibble) uploads; undefined gives OCS/ECS 12-bit uploads.
module denise_palette_writer #(
  parameter logic [8:0] COLORBASE = 9'h180,
  parameter logic [8:0] IDLE_ADR  = 9'h1FE
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clk7_en,
  input  logic        start,
  input  logic [7:0]  base_index,
  input  logic [8:0]  count,
  input  logic        src_valid,
  input  logic [23:0] src_data,
  output logic        src_ready,
  output logic [8:1]  reg_address_out,
  output logic [11:0] data_out,
  output logic [2:0]  bank_out,
  output logic        loct_out,
  output logic        wr_strobe,
  output logic        busy,
  output logic        done
);

`ifdef DENISE_PALWR_LOCT_EN
  typedef enum logic [2:0] {IDLE, FETCH, WR_HI, WR_LO, FIN} state_t;
`else
  typedef enum logic [2:0] {IDLE, FETCH, WR_HI, FIN} state_t;
`endif

  state_t      state, state_nx;
  logic [7:0]  idx, idx_nx;
  logic [8:0]  rem, rem_nx;
  logic [11:0] colour_hi;
  logic        fetch_fire;

  function automatic logic [11:0] hi_nibbles(input logic [23:0] rgb);
    return {rgb[23:20], rgb[15:12], rgb[7:4]};
  endfunction

  function automatic logic [11:0] lo_nibbles(input logic [23:0] rgb);
    return {rgb[19:16], rgb[11:8], rgb[3:0]};
  endfunction

  assign fetch_fire = (state == FETCH) && src_valid;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      idx   <= 8'd0;
      rem   <= 9'd0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      rem   <= rem_nx;
    end
  end

  // Colour holding registers are pure data and are only loaded on a handshake.
  always_ff @(posedge clk) begin
    if (fetch_fire) colour_hi <= hi_nibbles(src_data);
  end

`ifdef DENISE_PALWR_LOCT_EN
  logic [11:0] colour_lo;

  always_ff @(posedge clk) begin
    if (fetch_fire) colour_lo <= lo_nibbles(src_data);
  end
`else
  logic [11:0] unused_lo;
  assign unused_lo = lo_nibbles(src_data);
`endif

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    rem_nx   = rem;
    case (state)
      IDLE: begin
        if (start) begin
          idx_nx   = base_index;
          rem_nx   = count;
          state_nx = (count == 9'd0) ? FIN : FETCH;
        end
      end
      FETCH: begin
        if (src_valid) state_nx = WR_HI;
      end
`ifdef DENISE_PALWR_LOCT_EN
      WR_HI: begin
        if (clk7_en) state_nx = WR_LO;
      end
      WR_LO: begin
        if (clk7_en) begin
          idx_nx   = idx + 8'd1;
          rem_nx   = rem - 9'd1;
          state_nx = (rem == 9'd1) ? FIN : FETCH;
        end
      end
`else
      WR_HI: begin
        if (clk7_en) begin
          idx_nx   = idx + 8'd1;
          rem_nx   = rem - 9'd1;
          state_nx = (rem == 9'd1) ? FIN : FETCH;
        end
      end
`endif
      FIN: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Write-side outputs decode straight from state so they hold for the whole write state.
  always_comb begin
    reg_address_out = IDLE_ADR[8:1];
    data_out        = 12'd0;
    bank_out        = 3'd0;
    loct_out        = 1'b0;
    wr_strobe       = 1'b0;
    case (state)
      WR_HI: begin
        reg_address_out = {COLORBASE[8:6], idx[4:0]};
        bank_out        = idx[7:5];
        data_out        = colour_hi;
        wr_strobe       = clk7_en;
      end
`ifdef DENISE_PALWR_LOCT_EN
      WR_LO: begin
        reg_address_out = {COLORBASE[8:6], idx[4:0]};
        bank_out        = idx[7:5];
        loct_out        = 1'b1;
        data_out        = colour_lo;
        wr_strobe       = clk7_en;
      end
`endif
      default: ;
    endcase
  end

  assign src_ready = (state == FETCH);
  assign busy      = (state != IDLE) && (state != FIN);
  assign done      = (state == FIN);

endmodule

// File: tb/tb_denise_palette_writer.sv
// Scoreboard bench for denise_palette_writer: expected writes are queued as colours are offered
// and popped as strobes appear; honours DENISE_PALWR_LOCT_EN like the design.
module tb_denise_palette_writer;

`ifdef DENISE_PALWR_LOCT_EN
  localparam int WPC = 2;
`else
  localparam int WPC = 1;
`endif

  typedef struct packed {
    logic [7:0]  adr;
    logic [2:0]  bank;
    logic        loct;
    logic [11:0] data;
  } wr_t;

  logic        clk, reset_n, clk7_en, start, src_valid;
  logic [7:0]  base_index;
  logic [8:0]  count;
  logic [23:0] src_data;
  logic        src_ready, loct_out, wr_strobe, busy, done;
  logic [8:1]  reg_address_out;
  logic [11:0] data_out;
  logic [2:0]  bank_out;

  int  vec_cnt = 0;
  int  mis_cnt = 0;
  int  strobe_cnt = 0;
  int  done_cnt = 0;
  bit  c7_hold = 0;
  wr_t sb[$];

  denise_palette_writer dut (
    .clk(clk), .reset_n(reset_n), .clk7_en(clk7_en), .start(start),
    .base_index(base_index), .count(count), .src_valid(src_valid),
    .src_data(src_data), .src_ready(src_ready),
    .reg_address_out(reg_address_out), .data_out(data_out),
    .bank_out(bank_out), .loct_out(loct_out), .wr_strobe(wr_strobe),
    .busy(busy), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // 7 MHz enable: one clk cycle in four, changed just after the rising edge.
  initial begin
    int ph;
    ph = 0;
    clk7_en = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ph = (ph + 1) % 4;
      clk7_en = !c7_hold && (ph == 0);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      mis_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic wr_t mk(input logic [7:0] idx, input bit lo, input logic [23:0] c);
    wr_t w;
    int  a;
    logic [7:0] r, g, b;
    a = 'h180 + 2 * (int'(idx) % 32);
    r = c[23:16];
    g = c[15:8];
    b = c[7:0];
    w.adr  = 8'(a >> 1);
    w.bank = 3'(int'(idx) / 32);
    w.loct = lo;
    if (lo) w.data = {4'(r & 8'h0F), 4'(g & 8'h0F), 4'(b & 8'h0F)};
    else    w.data = {4'(r >> 4), 4'(g >> 4), 4'(b >> 4)};
    return w;
  endfunction

  always @(negedge clk) begin
    wr_t e;
    if (reset_n && wr_strobe) begin
      strobe_cnt++;
      chk("strobe_en", 32'(clk7_en), 32'd1);
      if (sb.size() == 0) chk("unexp_wr", 32'(sb.size()), 32'd1);
      else begin
        e = sb.pop_front();
        chk("wr", {8'd0, reg_address_out, bank_out, loct_out, data_out}, {8'd0, e});
      end
    end
    if (reset_n && done) begin
      done_cnt++;
      chk("busy_at_done", 32'(busy), 32'd0);
    end
  end

  task automatic wait_ready(input string tag);
    int w;
    w = 0;
    while (!src_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) chk(tag, 32'(src_ready), 32'd1);
  endtask

  task automatic stall_check(input int len);
    wait_ready("stall_rdy_to");
    for (int k = 0; k < len; k++) begin
      chk("stall_rdy", 32'(src_ready), 32'd1);
      chk("stall_strb", 32'(wr_strobe), 32'd0);
      chk("stall_adr", 32'(reg_address_out), 32'hFF);
      chk("stall_busy", 32'(busy), 32'd1);
      @(negedge clk);
    end
  endtask

  task automatic upload(input logic [7:0] base, input int cnt, input int stall_at, input bit poke);
    int s0, d0, w;
    logic [23:0] c;
    logic [7:0] idx;
    s0 = strobe_cnt;
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1;
    base_index = base;
    count = 9'(cnt);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'(cnt != 0));
    idx = base;
    for (int i = 0; i < cnt; i++) begin
      if (i == stall_at) stall_check(10);
      c = (cnt == 1) ? 24'h123456 : 24'($urandom);
      src_data = c;
      src_valid = 1'b1;
      sb.push_back(mk(idx, 1'b0, c));
      if (WPC == 2) sb.push_back(mk(idx, 1'b1, c));
      wait_ready("rdy_to");
      @(posedge clk);
      #1;
      src_valid = 1'b0;
      if (poke && i == 0) begin
        @(negedge clk);
        start = 1'b1;
        base_index = 8'h77;
        count = 9'd5;
        @(negedge clk);
        start = 1'b0;
      end
      idx = idx + 8'd1;
    end
    w = 0;
    while (!done && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("done_seen", 32'(done), 32'd1);
    if (cnt == 0) chk("done_lat0", 32'(w <= 2), 32'd1);
    repeat (3) @(negedge clk);
    chk("strobes", 32'(strobe_cnt - s0), 32'(cnt * WPC));
    chk("done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  task automatic idle_checks(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_rdy"}, 32'(src_ready), 32'd0);
    chk({tag, "_strb"}, 32'(wr_strobe), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_adr"}, 32'(reg_address_out), 32'hFF);
    chk({tag, "_data"}, 32'(data_out), 32'd0);
    chk({tag, "_bank"}, 32'(bank_out), 32'd0);
    chk({tag, "_loct"}, 32'(loct_out), 32'd0);
  endtask

  initial begin
    int s0;
    reset_n = 1'b0;
    start = 1'b0;
    src_valid = 1'b0;
    src_data = 24'd0;
    base_index = 8'd0;
    count = 9'd0;
    repeat (3) @(negedge clk);
    idle_checks("rst");
    reset_n = 1'b1;
    @(negedge clk);

    upload(8'h05, 1, -1, 1'b0);
    upload(8'hFF, 2, -1, 1'b0);
    upload(8'h10, 2, 1, 1'b0);
    upload(8'h00, 0, -1, 1'b0);
    upload(8'h08, 3, -1, 1'b1);
    upload(8'h20, 3, -1, 1'b0);
    upload(8'h00, 256, -1, 1'b0);

    // Abandon an upload while a write is being presented.
    c7_hold = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b1;
    base_index = 8'h03;
    count = 9'd4;
    @(negedge clk);
    start = 1'b0;
    src_data = 24'hABCDEF;
    src_valid = 1'b1;
    wait_ready("rst_rdy_to");
    @(posedge clk);
    #1;
    src_valid = 1'b0;
    @(negedge clk);
    chk("wrhi_adr", 32'(reg_address_out), 32'hC3);
    chk("wrhi_data", 32'(data_out), 32'hACE);
    chk("wrhi_loct", 32'(loct_out), 32'd0);
    reset_n = 1'b0;
    @(negedge clk);
    idle_checks("midrst");
    reset_n = 1'b1;
    c7_hold = 1'b0;
    s0 = strobe_cnt;
    repeat (20) @(negedge clk);
    chk("no_wr_after_rst", 32'(strobe_cnt - s0), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
    $finish;
  end

endmodule

// File: doc/denise_palette_writer.md
Name: denise_palette_writer

Overview:
- Register-bus transmitter that uploads 24-bit RGB palette entries into the Denise colour table through COLORxx register writes.
- Per colour it drives bank select, the 12-bit palette select (loct) and the 12-bit colour word: high nibbles first with loct=0, then low nibbles with loct=1.
- Sits beside the Copper/CPU register path inside Denise. A palette-load engine (OSD or scaler) feeds it through a valid/ready stream.

Parameters:
- COLORBASE, 9'h180, colour register base address (byte address; bit 0 unused).
- IDLE_ADR, 9'h1FE, register address driven while no write is in progress (NOP register).

Ports:
- clk  in  1  28MHz clock
- reset_n  in  1  synchronous active-low reset
- clk7_en  in  1  7MHz clock enable; writes occur only on cycles with clk7_en=1
- start  in  1  begin an upload; sampled only in IDLE
- base_index  in  8  first palette index, {bank[2:0], colour[4:0]}
- count  in  9  number of colours, 0..256
- src_valid  in  1  source colour valid
- src_data  in  24  {R[7:0], G[7:0], B[7:0]}
- src_ready  out  1  writer accepts src_data this cycle
- reg_address_out  out  9:1  register address to the colour table
- data_out  out  12  colour data to the colour table
- bank_out  out  3  colour bank select
- loct_out  out  1  0 = write both halves, 1 = write low half only
- wr_strobe  out  1  a write is being presented this cycle (always coincides with clk7_en=1)
- busy  out  1  upload in progress
- done  out  1  one-cycle pulse when the last write completes

Behaviour:
- Reset (reset_n=0 at a clk edge) forces:
  - state=IDLE
  - src_ready=0, wr_strobe=0, busy=0, done=0
  - reg_address_out=IDLE_ADR[8:1], data_out=0, bank_out=0, loct_out=0
  - internal index and remaining counters cleared
  - Reset mid-upload abandons the upload; no further strobes.
- States: IDLE, FETCH, WR_HI, WR_LO, FIN.
- IDLE: on start=1, latch idx=base_index and rem=count.
  - If count=0, go to FIN; otherwise go to FETCH.
  - busy=1 from the cycle after start. start while busy is ignored.
- FETCH: src_ready=1. On src_valid&src_ready, capture:
  - hi={R[7:4],G[7:4],B[7:4]}
  - lo={R[3:0],G[3:0],B[3:0]}
  - then go to WR_HI.
- WR_HI: reg_address_out=COLORBASE[8:6],idx[4:0]; bank_out=idx[7:5]; loct_out=0; data_out=hi.
  - wr_strobe=clk7_en (combinational from state).
  - On clk7_en=1, go to WR_LO.
- WR_LO: same address and bank; loct_out=1; data_out=lo; wr_strobe=clk7_en.
  - On clk7_en=1: idx<=idx+1 (8-bit wrap 255->0), rem<=rem-1.
  - If rem==1, go to FIN; otherwise go to FETCH.
- FIN: done=1 for exactly one cycle, busy=0 in the same cycle, then go to IDLE.
- Address, bank, loct and data are stable for the whole WR_* state, not only in the strobe cycle.
- Outside WR_* states: reg_address_out=IDLE_ADR[8:1] and wr_strobe=0.
- Minimum cost per colour: 1 fetch cycle plus 2 clk7_en-qualified write cycles. Source stalls simply hold FETCH.
- count=256 with base_index=8'h00 writes all 8 banks. A nonzero base wraps the index modulo 256.

Optional Feature:
- Macro: DENISE_PALWR_LOCT_EN.
- Defined: AGA 24-bit behaviour as above, two writes per colour.
- Not defined: OCS/ECS 12-bit mode.
  - WR_LO state is removed; WR_HI advances idx/rem itself and returns to FETCH or FIN.
  - loct_out is constant 0 and lo is not stored.
  - bank_out still follows idx[7:5].

Test Plan:
- Reset mid-upload: assert reset_n=0 in WR_HI -> next cycle state IDLE, wr_strobe=0, busy=0, reg_address_out=9'h1FE>>1; no further writes.
- Single colour: base_index=8'h05, count=1, src_data=24'h12_34_56, clk7_en every 4th cycle -> two writes:
  - address 9'h18A, bank 0, loct 0, data 12'h135
  - then address 9'h18A, loct 1, data 12'h246
  - then a single done pulse.
- Bank and wrap: base_index=8'hFF, count=2 -> first colour addr 9'h1BE with bank 7; second colour addr 9'h180 with bank 0; done after 4 strobes.
- Source stall: src_valid low for 10 cycles between colours -> src_ready held 1, no strobes and outputs at IDLE_ADR during the stall, busy stays 1.
- count=0 and start-while-busy:
  - count=0 -> done pulse within 2 cycles, zero strobes.
  - start pulsed during an active upload -> ignored; write sequence unchanged.
- Without DENISE_PALWR_LOCT_EN: count=3, base_index=8'h20 -> exactly 3 strobes, all loct 0, bank 1, addresses 9'h180/9'h182/9'h184.
